// File: rtl/synth_slot_scheduler.sv
// Per-sample slot sequencer: on each LRCK_1X rising edge, walks all oscillator slots
// then all envelope slots, emitting voice/index addresses and valid strobes as clock enables.
module synth_slot_scheduler #(
    parameter int unsigned VOICES      = 8,
    parameter int unsigned V_OSC       = 4,
    parameter int unsigned V_ENVS      = 8,
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned VB          = (VOICES > 1) ? $clog2(VOICES) : 1,
    parameter int unsigned OB          = (V_OSC > 1) ? $clog2(V_OSC) : 1,
    parameter int unsigned EB          = (V_ENVS > 1) ? $clog2(V_ENVS) : 1,
    parameter int unsigned PB          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
    input  logic          OSC_CLK,
    input  logic          iRST,
    input  logic          LRCK_1X,
    input  logic          iENABLE,
    input  logic          iOVR_CLR,
    output logic          oFRAME_START,
    output logic          oBUSY,
    output logic          oOSC_VALID,
    output logic [VB-1:0] oOSC_VOICE,
    output logic [OB-1:0] oOSC_IDX,
    output logic          oENV_VALID,
    output logic [VB-1:0] oENV_VOICE,
    output logic [EB-1:0] oENV_IDX,
    output logic [PB-1:0] oSLOT_PHASE,
    output logic          oOVERRUN
);

    typedef enum logic [1:0] {IDLE, OSC, ENV} state_t;

    localparam logic [VB-1:0] LAST_VOICE = VB'(VOICES - 1);
    localparam logic [OB-1:0] LAST_OSC   = OB'(V_OSC - 1);
    localparam logic [EB-1:0] LAST_ENV   = EB'(V_ENVS - 1);
    localparam logic [PB-1:0] LAST_PHASE = PB'(SLOT_CYCLES - 1);

    state_t     state;
    logic       lrckSync1;
    logic       lrckSync2;
    logic       lrckPrev;
    logic [1:0] syncValid;
    logic       lrckEdge;
    logic       phaseLast;

    assign lrckEdge  = lrckSync2 & ~lrckPrev;
    assign phaseLast = (oSLOT_PHASE == LAST_PHASE);

    always_ff @(posedge OSC_CLK or posedge iRST) begin
        if (iRST) begin
            state        <= IDLE;
            lrckSync1    <= 1'b0;
            lrckSync2    <= 1'b0;
            lrckPrev     <= 1'b1;
            syncValid    <= 2'b00;
            oFRAME_START <= 1'b0;
            oBUSY        <= 1'b0;
            oOSC_VALID   <= 1'b0;
            oOSC_VOICE   <= '0;
            oOSC_IDX     <= '0;
            oENV_VALID   <= 1'b0;
            oENV_VOICE   <= '0;
            oENV_IDX     <= '0;
            oSLOT_PHASE  <= '0;
            oOVERRUN     <= 1'b0;
        end else begin
            lrckSync1 <= LRCK_1X;
            lrckSync2 <= lrckSync1;
            syncValid <= {syncValid[0], 1'b1};
            // Hold prev high until the synchroniser holds a real sample, so a level
            // already high at reset release is not mistaken for a rising edge.
            lrckPrev  <= syncValid[1] ? lrckSync2 : 1'b1;

            oFRAME_START <= 1'b0;

            if (lrckEdge && (state != IDLE)) begin
                oOVERRUN <= 1'b1;
            end else if (iOVR_CLR) begin
                oOVERRUN <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (lrckEdge && iENABLE) begin
                        state        <= OSC;
                        oFRAME_START <= 1'b1;
                        oOSC_VALID   <= 1'b1;
                        oBUSY        <= 1'b1;
                    end
                end
                OSC: begin
                    if (phaseLast) begin
                        oSLOT_PHASE <= '0;
                        if (oOSC_IDX == LAST_OSC) begin
                            oOSC_IDX <= '0;
                            if (oOSC_VOICE == LAST_VOICE) begin
                                state      <= ENV;
                                oOSC_VOICE <= '0;
                                oOSC_VALID <= 1'b0;
                                oENV_VALID <= 1'b1;
                            end else begin
                                oOSC_VOICE <= oOSC_VOICE + VB'(1);
                            end
                        end else begin
                            oOSC_IDX <= oOSC_IDX + OB'(1);
                        end
                    end else begin
                        oSLOT_PHASE <= oSLOT_PHASE + PB'(1);
                    end
                end
                ENV: begin
                    if (phaseLast) begin
                        oSLOT_PHASE <= '0;
                        if (oENV_IDX == LAST_ENV) begin
                            oENV_IDX <= '0;
                            if (oENV_VOICE == LAST_VOICE) begin
                                state      <= IDLE;
                                oENV_VOICE <= '0;
                                oENV_VALID <= 1'b0;
                                oBUSY      <= 1'b0;
                            end else begin
                                oENV_VOICE <= oENV_VOICE + VB'(1);
                            end
                        end else begin
                            oENV_IDX <= oENV_IDX + EB'(1);
                        end
                    end else begin
                        oSLOT_PHASE <= oSLOT_PHASE + PB'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
